id_ex_operand_stage: RTL and testbench
======================================

// Module: id_ex_operand_stage
// PURPOSE
//  ID/EX pipeline stage directly downstream of the 2-read/1-write register file (rf).
//  - Captures rf read ports p0/p1 (valid late in the ID cycle) plus decoded control.
//  - Applies EX/MEM and MEM/WB operand forwarding.
//  - Detects load-use hazards and inserts a bubble.
//  - Hands resolved operands to the ALU / EX stage.
// PARAMETERS
//  DW  16  datapath width; matches rf port width
//  AW  4   register address width; 16 regs, R0 hardwired to zero
// PORTS
//  clk             in   1   system clock, rising edge
//  rst             in   1   synchronous, active-high reset
//  stall           in   1   external pipeline hold, e.g. memory wait
//  flush           in   1   branch-taken squash of the ID/EX contents
//  id_valid        in   1   ID holds a real instruction
//  id_p0_addr      in   AW  source reg 0 (same value driven to rf p0_addr)
//  id_p1_addr      in   AW  source reg 1 (same value driven to rf p1_addr)
//  id_re0          in   1   source 0 used
//  id_re1          in   1   source 1 used
//  id_dst_addr     in   AW  destination reg
//  id_we           in   1   instruction writes dst
//  id_is_load      in   1   instruction is a load
//  rf_p0           in   DW  rf read data, port 0
//  rf_p1           in   DW  rf read data, port 1
//  exm_dst_addr    in   AW  EX/MEM destination
//  exm_we          in   1   EX/MEM write enable
//  exm_result      in   DW  EX/MEM ALU result
//  mwb_dst_addr    in   AW  MEM/WB destination (also rf dst_addr)
//  mwb_we          in   1   MEM/WB write enable (also rf we)
//  mwb_result      in   DW  MEM/WB writeback data (also rf dst)
//  ex_valid        out  1   EX stage holds a real instruction
//  ex_src0         out  DW  resolved operand 0
//  ex_src1         out  DW  resolved operand 1
//  ex_dst_addr     out  AW  registered destination
//  ex_we           out  1   registered write enable, gated by ex_valid
//  ex_is_load      out  1   registered load flag, gated by ex_valid
//  load_use_stall  out  1   combinational; ID must hold this cycle
// BEHAVIOUR
//  - Reset: all registers clear; ex_valid=0, ex_src0/1=0, ex_dst_addr=0, ex_we=0, ex_is_load=0.
//  - Registered state (posedge):
//    - valid, src0_q, src1_q, addr0_q, addr1_q, re0_q, re1_q, dst_q, we_q, is_load_q.
//  - Forwarding, combinational, per operand n:
//    - addr_q==0 or !re_q            -> 0.
//    - exm_we & exm_dst_addr==addr_q -> exm_result.
//    - mwb_we & mwb_dst_addr==addr_q -> mwb_result.
//    - otherwise                     -> src_q.
//    - Priority is top to bottom: EX/MEM wins over MEM/WB.
//  - Same-cycle ID-vs-writeback collisions are already bypassed inside rf; rf_p0/p1 are taken as-is.
//  - load_use_stall = valid & is_load_q & we_q & dst_q!=0 & id_valid & !flush
//    & ((id_re0 & id_p0_addr==dst_q) | (id_re1 & id_p1_addr==dst_q)).
//  - Update priority each edge; first matching row wins:
//    1. rst: clear all.
//    2. flush: valid<=0, we_q<=0, is_load_q<=0; flush beats stall.
//    3. stall: hold all fields. src0_q/src1_q reload with the current forwarded ex_src0/ex_src1 (refresh).
//       This keeps operands correct when a producer drains through WB during a multi-cycle hold.
//    4. load_use_stall: insert bubble (valid<=0, we_q<=0, is_load_q<=0). ID is held upstream.
//    5. else: load all fields from ID/rf; valid<=id_valid.
//  - Latency: 1 cycle from ID to EX; forwarding adds no cycles.
//  - Load-use costs exactly 1 bubble. The load result then forwards from MEM/WB.
//  - ex_we = we_q & valid; ex_is_load = is_load_q & valid. ex_dst_addr is unconditioned.
// STRUCTURE
//  - cpu_pkg: DW, AW, REG_ZERO localparam; shared by rf, this stage and the hazard logic.
//  - Sub-module fwd_mux (one per operand, 2 instances).
//    - Inputs: addr, re, src_q, exm_*, mwb_*.
//    - Output: resolved operand.
//  - This module holds the pipeline registers, hazard compare and update-priority logic.
// TESTING
//  1. rst=1 for 2 cycles with all inputs toggling -> every output 0, load_use_stall 0.
//  2. ID R3+R4 (rf_p0=0x1111, rf_p1=0x2222), no hazards -> next cycle ex_src0=0x1111, ex_src1=0x2222, ex_valid=1.
//  3. EX/MEM writes R3=0xAAAA and MEM/WB writes R3=0xBBBB; EX reads R3 -> ex_src0=0xAAAA (EX/MEM priority).
//  4. EX holds a load to R5; ID reads R5 -> load_use_stall=1 one cycle, ex_valid=0 next cycle.
//     Load then completes with mwb_result=0x5A5A -> ex_src0=0x5A5A.
//  5. EX reads R2; stall=1 for 3 cycles while a write R2=0x7777 passes through MEM/WB in cycle 2 only
//     -> ex_src0 stays 0x7777 through cycle 3 and after release.
//  6. flush and stall asserted together -> ex_valid=0, ex_we=0.
//     A forwarding match on R0 (exm_dst_addr=0, exm_we=1) -> operand stays 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared core widths and register-file constants.
// Used by the register file, the ID/EX stage and the hazard logic.
package cpu_pkg;

  localparam int DW = 16;
  localparam int AW = 4;

  localparam logic [AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Per-operand bypass select: R0/unused, EX/MEM, MEM/WB, then the
// value held in the ID/EX register.
module fwd_mux
  import cpu_pkg::*;
#(
  parameter int DW_P = DW,
  parameter int AW_P = AW
) (
  input  logic [AW_P-1:0] addr,
  input  logic            re,
  input  logic [DW_P-1:0] src_q,
  input  logic [AW_P-1:0] exm_dst_addr,
  input  logic            exm_we,
  input  logic [DW_P-1:0] exm_result,
  input  logic [AW_P-1:0] mwb_dst_addr,
  input  logic            mwb_we,
  input  logic [DW_P-1:0] mwb_result,
  output logic [DW_P-1:0] opnd
);

  always_comb begin
    opnd = src_q;
    if (addr == AW_P'(REG_ZERO) || !re) begin
      opnd = '0;
    end else if (exm_we && exm_dst_addr == addr) begin
      opnd = exm_result;
    end else if (mwb_we && mwb_dst_addr == addr) begin
      opnd = mwb_result;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding and
// load-use bubble insertion.
module id_ex_operand_stage
  import cpu_pkg::*;
#(
  parameter int DW_P = DW,
  parameter int AW_P = AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [AW_P-1:0] id_p0_addr,
  input  logic [AW_P-1:0] id_p1_addr,
  input  logic            id_re0,
  input  logic            id_re1,
  input  logic [AW_P-1:0] id_dst_addr,
  input  logic            id_we,
  input  logic            id_is_load,
  input  logic [DW_P-1:0] rf_p0,
  input  logic [DW_P-1:0] rf_p1,
  input  logic [AW_P-1:0] exm_dst_addr,
  input  logic            exm_we,
  input  logic [DW_P-1:0] exm_result,
  input  logic [AW_P-1:0] mwb_dst_addr,
  input  logic            mwb_we,
  input  logic [DW_P-1:0] mwb_result,
  output logic            ex_valid,
  output logic [DW_P-1:0] ex_src0,
  output logic [DW_P-1:0] ex_src1,
  output logic [AW_P-1:0] ex_dst_addr,
  output logic            ex_we,
  output logic            ex_is_load,
  output logic            load_use_stall
);

  logic            valid_q, valid_d;
  logic [DW_P-1:0] src0_q, src0_d;
  logic [DW_P-1:0] src1_q, src1_d;
  logic [AW_P-1:0] addr0_q, addr0_d;
  logic [AW_P-1:0] addr1_q, addr1_d;
  logic            re0_q, re0_d;
  logic            re1_q, re1_d;
  logic [AW_P-1:0] dst_q, dst_d;
  logic            we_q, we_d;
  logic            is_load_q, is_load_d;

  logic            hit0, hit1;

  fwd_mux #(.DW_P(DW_P), .AW_P(AW_P)) u_fwd0 (
    .addr         (addr0_q),
    .re           (re0_q),
    .src_q        (src0_q),
    .exm_dst_addr (exm_dst_addr),
    .exm_we       (exm_we),
    .exm_result   (exm_result),
    .mwb_dst_addr (mwb_dst_addr),
    .mwb_we       (mwb_we),
    .mwb_result   (mwb_result),
    .opnd         (ex_src0)
  );

  fwd_mux #(.DW_P(DW_P), .AW_P(AW_P)) u_fwd1 (
    .addr         (addr1_q),
    .re           (re1_q),
    .src_q        (src1_q),
    .exm_dst_addr (exm_dst_addr),
    .exm_we       (exm_we),
    .exm_result   (exm_result),
    .mwb_dst_addr (mwb_dst_addr),
    .mwb_we       (mwb_we),
    .mwb_result   (mwb_result),
    .opnd         (ex_src1)
  );

  assign hit0 = id_re0 && id_p0_addr == dst_q;
  assign hit1 = id_re1 && id_p1_addr == dst_q;

  assign load_use_stall = valid_q && is_load_q && we_q
                       && dst_q != AW_P'(REG_ZERO)
                       && id_valid && !flush
                       && (hit0 || hit1);

  always_comb begin
    valid_d   = valid_q;
    src0_d    = src0_q;
    src1_d    = src1_q;
    addr0_d   = addr0_q;
    addr1_d   = addr1_q;
    re0_d     = re0_q;
    re1_d     = re1_q;
    dst_d     = dst_q;
    we_d      = we_q;
    is_load_d = is_load_q;
    if (flush) begin
      valid_d   = 1'b0;
      we_d      = 1'b0;
      is_load_d = 1'b0;
    end else if (stall) begin
      // refresh so a producer draining through WB is not lost
      src0_d = ex_src0;
      src1_d = ex_src1;
    end else if (load_use_stall) begin
      valid_d   = 1'b0;
      we_d      = 1'b0;
      is_load_d = 1'b0;
    end else begin
      valid_d   = id_valid;
      src0_d    = rf_p0;
      src1_d    = rf_p1;
      addr0_d   = id_p0_addr;
      addr1_d   = id_p1_addr;
      re0_d     = id_re0;
      re1_d     = id_re1;
      dst_d     = id_dst_addr;
      we_d      = id_we;
      is_load_d = id_is_load;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      src0_q    <= '0;
      src1_q    <= '0;
      addr0_q   <= '0;
      addr1_q   <= '0;
      re0_q     <= 1'b0;
      re1_q     <= 1'b0;
      dst_q     <= '0;
      we_q      <= 1'b0;
      is_load_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      src0_q    <= src0_d;
      src1_q    <= src1_d;
      addr0_q   <= addr0_d;
      addr1_q   <= addr1_d;
      re0_q     <= re0_d;
      re1_q     <= re1_d;
      dst_q     <= dst_d;
      we_q      <= we_d;
      is_load_q <= is_load_d;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_dst_addr = dst_q;
  assign ex_we       = we_q && valid_q;
  assign ex_is_load  = is_load_q && valid_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed scoreboard bench for the ID/EX operand stage.
// Expectations are queued per cycle and checked on the falling edge.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush;
  logic        id_valid;
  logic [3:0]  id_p0_addr, id_p1_addr;
  logic        id_re0, id_re1;
  logic [3:0]  id_dst_addr;
  logic        id_we, id_is_load;
  logic [15:0] rf_p0, rf_p1;
  logic [3:0]  exm_dst_addr;
  logic        exm_we;
  logic [15:0] exm_result;
  logic [3:0]  mwb_dst_addr;
  logic        mwb_we;
  logic [15:0] mwb_result;
  logic        ex_valid;
  logic [15:0] ex_src0, ex_src1;
  logic [3:0]  ex_dst_addr;
  logic        ex_we, ex_is_load;
  logic        load_use_stall;

  id_ex_operand_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .id_valid       (id_valid),
    .id_p0_addr     (id_p0_addr),
    .id_p1_addr     (id_p1_addr),
    .id_re0         (id_re0),
    .id_re1         (id_re1),
    .id_dst_addr    (id_dst_addr),
    .id_we          (id_we),
    .id_is_load     (id_is_load),
    .rf_p0          (rf_p0),
    .rf_p1          (rf_p1),
    .exm_dst_addr   (exm_dst_addr),
    .exm_we         (exm_we),
    .exm_result     (exm_result),
    .mwb_dst_addr   (mwb_dst_addr),
    .mwb_we         (mwb_we),
    .mwb_result     (mwb_result),
    .ex_valid       (ex_valid),
    .ex_src0        (ex_src0),
    .ex_src1        (ex_src1),
    .ex_dst_addr    (ex_dst_addr),
    .ex_we          (ex_we),
    .ex_is_load     (ex_is_load),
    .load_use_stall (load_use_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       nm;
    logic        v;
    logic [15:0] s0;
    logic [15:0] s1;
    logic [3:0]  dst;
    logic        we;
    logic        ld;
    logic        lus;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc == cyc) begin
      exp_t e;
      e = sb.pop_front();
      n_chk++;
      if (ex_valid !== e.v || ex_src0 !== e.s0 || ex_src1 !== e.s1 ||
          ex_dst_addr !== e.dst || ex_we !== e.we ||
          ex_is_load !== e.ld || load_use_stall !== e.lus) begin
        $display("FAIL %s: got v=%b s0=%h s1=%h dst=%h we=%b ld=%b lus=%b exp v=%b s0=%h s1=%h dst=%h we=%b ld=%b lus=%b",
                 e.nm, ex_valid, ex_src0, ex_src1, ex_dst_addr, ex_we,
                 ex_is_load, load_use_stall, e.v, e.s0, e.s1, e.dst,
                 e.we, e.ld, e.lus);
      end else begin
        n_pass++;
      end
    end
  end

  task automatic expect_now(input string nm, input logic v,
                            input logic [15:0] s0, input logic [15:0] s1,
                            input logic [3:0] dst, input logic we,
                            input logic ld, input logic lus);
    exp_t e;
    e.cyc = cyc; e.nm = nm; e.v = v; e.s0 = s0; e.s1 = s1;
    e.dst = dst; e.we = we; e.ld = ld; e.lus = lus;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; flush = 0;
    id_valid = 0; id_p0_addr = 0; id_p1_addr = 0;
    id_re0 = 0; id_re1 = 0; id_dst_addr = 0;
    id_we = 0; id_is_load = 0; rf_p0 = 0; rf_p1 = 0;
    exm_dst_addr = 0; exm_we = 0; exm_result = 0;
    mwb_dst_addr = 0; mwb_we = 0; mwb_result = 0;
  endtask

  task automatic issue(input logic [3:0] a0, input logic r0,
                       input logic [3:0] a1, input logic r1,
                       input logic [15:0] d0, input logic [15:0] d1,
                       input logic [3:0] dst, input logic we,
                       input logic ld);
    id_valid = 1; id_p0_addr = a0; id_re0 = r0;
    id_p1_addr = a1; id_re1 = r1; rf_p0 = d0; rf_p1 = d1;
    id_dst_addr = dst; id_we = we; id_is_load = ld;
  endtask

  initial begin
    idle();
    rst = 1;
    step();
    // reset with toggling inputs
    for (int i = 0; i < 2; i++) begin
      {stall, flush, id_valid, id_re0, id_re1, id_we, id_is_load} = 7'($urandom);
      {id_p0_addr, id_p1_addr, id_dst_addr} = 12'($urandom);
      {rf_p0, rf_p1} = $urandom;
      {exm_result, mwb_result} = $urandom;
      {exm_dst_addr, mwb_dst_addr, exm_we, mwb_we} = 10'($urandom);
      expect_now("reset", 0, 16'h0, 16'h0, 4'h0, 0, 0, 0);
      step();
    end
    rst = 0;
    idle();
    step();

    issue(4'd3, 1, 4'd4, 1, 16'h1111, 16'h2222, 4'd6, 1, 0);
    step();
    idle();
    expect_now("basic", 1, 16'h1111, 16'h2222, 4'd6, 1, 0, 0);
    step();

    // EX reads R3/R4 again: EX/MEM beats MEM/WB on R3
    issue(4'd3, 1, 4'd4, 1, 16'h1111, 16'h2222, 4'd6, 1, 0);
    step();
    idle();
    exm_we = 1; exm_dst_addr = 4'd3; exm_result = 16'hAAAA;
    mwb_we = 1; mwb_dst_addr = 4'd3; mwb_result = 16'hBBBB;
    issue(4'd3, 1, 4'd4, 1, 16'h1234, 16'h5678, 4'd7, 0, 0);
    expect_now("exm_prio", 1, 16'hAAAA, 16'h2222, 4'd6, 1, 0, 0);
    step();
    idle();
    exm_we = 1; exm_dst_addr = 4'd9; exm_result = 16'h9999;
    mwb_we = 1; mwb_dst_addr = 4'd4; mwb_result = 16'hCCCC;
    issue(4'd1, 1, 4'd2, 0, 16'h0101, 16'h0202, 4'd5, 1, 1);
    expect_now("mwb_fwd", 1, 16'h1234, 16'hCCCC, 4'd7, 0, 0, 0);
    step();

    // load to R5 in EX, consumer of R5 in ID
    idle();
    issue(4'd5, 1, 4'd6, 1, 16'h0000, 16'h0606, 4'd8, 1, 0);
    expect_now("lu_detect", 1, 16'h0101, 16'h0000, 4'd5, 1, 1, 1);
    step();
    expect_now("lu_bubble", 0, 16'h0101, 16'h0000, 4'd5, 0, 0, 0);
    step();
    mwb_we = 1; mwb_dst_addr = 4'd5; mwb_result = 16'h5A5A;
    issue(4'd2, 1, 4'd0, 0, 16'h0222, 16'h0000, 4'd10, 1, 0);
    expect_now("lu_fwd", 1, 16'h5A5A, 16'h0606, 4'd8, 1, 0, 0);
    step();

    // hold for 3 cycles while R2 drains through MEM/WB in cycle 2
    idle();
    stall = 1;
    expect_now("stall_c1", 1, 16'h0222, 16'h0000, 4'd10, 1, 0, 0);
    step();
    mwb_we = 1; mwb_dst_addr = 4'd2; mwb_result = 16'h7777;
    expect_now("stall_c2", 1, 16'h7777, 16'h0000, 4'd10, 1, 0, 0);
    step();
    mwb_we = 0; mwb_result = 16'h0000;
    expect_now("stall_c3", 1, 16'h7777, 16'h0000, 4'd10, 1, 0, 0);
    step();
    stall = 0;
    issue(4'd0, 1, 4'd3, 1, 16'hFFFF, 16'h0333, 4'd11, 1, 0);
    expect_now("stall_rel", 1, 16'h7777, 16'h0000, 4'd10, 1, 0, 0);
    step();

    // R0 never forwards; flush beats stall
    idle();
    exm_we = 1; exm_dst_addr = 4'd0; exm_result = 16'hDEAD;
    flush = 1; stall = 1;
    expect_now("r0_fwd", 1, 16'h0000, 16'h0333, 4'd11, 1, 0, 0);
    step();
    flush = 0; stall = 0;
    expect_now("flush", 0, 16'h0000, 16'h0333, 4'd11, 0, 0, 0);
    step();

    idle();
    step();
    step();
    n_chk++;
    if (sb.size() != 0)
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    else
      n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
